alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 131 +++++++++++++
 tb/tb_alu_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-stage registered ALU with valid/ready handshake and a chained carry flag.
module alu_pipe #(
  parameter int WIDTH     = 16,
  parameter bit CARRY_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       select,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             compare,
  output logic             carry_flag
);
  logic             accept;
  logic             is_add, add_cin, add_ov, co, ov;
  logic [WIDTH-1:0] add_x, add_y, res;
  logic [WIDTH:0]   sum;
  logic             out_valid_q, out_valid_d, carry_out_q, carry_out_d, zero_q, zero_d;
  logic             negative_q, negative_d, overflow_q, overflow_d, compare_q, compare_d;
  logic             carry_flag_q, carry_flag_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Subtracts run through the same adder as x + ~y + cin, so carry_out=1 means no borrow.
  always_comb begin
    add_x   = in_a;
    add_y   = in_b;
    add_cin = 1'b0;
    is_add  = 1'b1;
    case (select)
      4'd1: ;
      4'd2: add_cin = carry_flag_q;
      4'd3, 4'd13: begin add_y = ~in_b; add_cin = 1'b1; end
      4'd4: begin add_y = ~in_b; add_cin = carry_flag_q; end
      4'd5: begin add_y = '0; add_cin = 1'b1; end
      4'd6: add_y = '1;
      4'd7: begin add_x = in_b; add_y = ~in_a; add_cin = 1'b1; end
      default: is_add = 1'b0;
    endcase
  end
  assign sum    = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_ov = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
  always_comb begin
    res = in_a;
    co  = 1'b0;
    ov  = 1'b0;
    if (mode) begin
      case (select)
        4'd0:  res = ~in_a;
        4'd1:  res = ~(in_a | in_b);
        4'd2:  res = ~in_a & in_b;
        4'd3:  res = '0;
        4'd4:  res = ~(in_a & in_b);
        4'd5:  res = ~in_b;
        4'd6:  res = in_a ^ in_b;
        4'd7:  res = in_a & ~in_b;
        4'd8:  res = ~in_a | in_b;
        4'd9:  res = ~(in_a ^ in_b);
        4'd10: res = in_b;
        4'd11: res = in_a & in_b;
        4'd12: res = '1;
        4'd13: res = in_a | ~in_b;
        4'd14: res = in_a | in_b;
        default: res = in_a;
      endcase
    end else if (is_add) begin
      res = (select == 4'd13) ? in_a : sum[WIDTH-1:0];
      co  = sum[WIDTH];
      ov  = add_ov;
    end else begin
      case (select)
        4'd8:  begin res = {in_a[WIDTH-2:0], 1'b0};          co = in_a[WIDTH-1]; end
        4'd9:  begin res = {1'b0, in_a[WIDTH-1:1]};          co = in_a[0]; end
        4'd10: begin res = {in_a[WIDTH-1], in_a[WIDTH-1:1]}; co = in_a[0]; end
        4'd11: begin res = {in_a[WIDTH-2:0], carry_flag_q};  co = in_a[WIDTH-1]; end
        4'd12: begin res = {carry_flag_q, in_a[WIDTH-1:1]};  co = in_a[0]; end
        4'd15: co = 1'b1;
        default: ;
      endcase
    end
  end
  always_comb begin
    out_valid_d  = accept || (out_valid_q && !out_ready);
    alu_out_d    = accept ? res : alu_out_q;
    carry_out_d  = accept ? co : carry_out_q;
    zero_d       = accept ? (res == '0) : zero_q;
    negative_d   = accept ? res[WIDTH-1] : negative_q;
    overflow_d   = accept ? ov : overflow_q;
    compare_d    = accept ? (in_a == in_b) : compare_q;
    carry_flag_d = (accept && !mode) ? co : carry_flag_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      alu_out_q    <= '0;
      carry_out_q  <= 1'b0;
      zero_q       <= 1'b0;
      negative_q   <= 1'b0;
      overflow_q   <= 1'b0;
      compare_q    <= 1'b0;
      carry_flag_q <= CARRY_RST;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_out_q    <= alu_out_d;
      carry_out_q  <= carry_out_d;
      zero_q       <= zero_d;
      negative_q   <= negative_d;
      overflow_q   <= overflow_d;
      compare_q    <= compare_d;
      carry_flag_q <= carry_flag_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign alu_out    = alu_out_q;
  assign carry_out  = carry_out_q;
  assign zero       = zero_q;
  assign negative   = negative_q;
  assign overflow   = overflow_q;
  assign compare    = compare_q;
  assign carry_flag = carry_flag_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe (WIDTH=16, CARRY_RST=1) with hand-computed expectations.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, mode = 1'b0, out_valid, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0, alu_out;
  logic [3:0]  select = '0;
  logic        carry_out, zero, negative, overflow, compare, carry_flag;
  logic [22:0] st, exp_st;
  int          n_cmp = 0, n_bad = 0;
  alu_pipe #(.WIDTH(16), .CARRY_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .select(select), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .carry_out(carry_out), .zero(zero), .negative(negative), .overflow(overflow),
    .compare(compare), .carry_flag(carry_flag)
  );
  always #5 clk = ~clk;
  // {out_valid, alu_out, carry_out, zero, negative, overflow, compare, carry_flag}
  assign st = {out_valid, alu_out, carry_out, zero, negative, overflow, compare, carry_flag};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic m, input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    mode = m; select = s; in_a = a; in_b = b; in_valid = 1'b1;
    step();
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    exp_st = {1'b0, 16'h0000, 6'b000001};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL reset_state: got %h want %h", st, exp_st); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask
  task automatic test_add_wrap();
    out_ready = 1'b1;
    go(1'b0, 4'd1, 16'hFFFF, 16'h0001);
    exp_st = {1'b1, 16'h0000, 6'b110001};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL add_wrap: got %h want %h", st, exp_st); end
    in_valid = 1'b0;
  endtask
  task automatic test_sub();
    go(1'b0, 4'd3, 16'h8000, 16'h0001);
    exp_st = {1'b1, 16'h7FFF, 6'b100101};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL sub_ovf: got %h want %h", st, exp_st); end
    go(1'b0, 4'd3, 16'h0000, 16'h0001);
    exp_st = {1'b1, 16'hFFFF, 6'b001000};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL sub_borrow: got %h want %h", st, exp_st); end
    in_valid = 1'b0;
  endtask
  task automatic test_carry_chain();
    go(1'b0, 4'd1, 16'hFFFF, 16'h0001);
    exp_st = {1'b1, 16'h0000, 6'b110001};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL chain_add: got %h want %h", st, exp_st); end
    go(1'b0, 4'd2, 16'h0000, 16'h0000);
    exp_st = {1'b1, 16'h0001, 6'b000010};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL chain_adc: got %h want %h", st, exp_st); end
    in_valid = 1'b0;
  endtask
  task automatic test_back_to_back();
    // {mode, select, a, b, expected alu_out, co z n ov cmp cf}; applied on consecutive cycles
    logic [58:0] v [18] = '{
      {1'b0, 4'd5,  16'h7FFF, 16'h0000, 16'h8000, 6'b001100},
      {1'b0, 4'd6,  16'h0000, 16'h0000, 16'hFFFF, 6'b001010},
      {1'b0, 4'd7,  16'h0003, 16'h0005, 16'h0002, 6'b100001},
      {1'b0, 4'd8,  16'h8001, 16'h0000, 16'h0002, 6'b100001},
      {1'b0, 4'd9,  16'h8001, 16'h0000, 16'h4000, 6'b100001},
      {1'b0, 4'd10, 16'h8001, 16'h0000, 16'hC000, 6'b101001},
      {1'b0, 4'd13, 16'h0005, 16'h0005, 16'h0005, 6'b100011},
      {1'b0, 4'd14, 16'h0000, 16'h0001, 16'h0000, 6'b010000},
      {1'b0, 4'd0,  16'h1234, 16'h0000, 16'h1234, 6'b000000},
      {1'b1, 4'd6,  16'hF0F0, 16'hFF00, 16'h0FF0, 6'b000000},
      {1'b1, 4'd2,  16'hF0F0, 16'hFF00, 16'h0F00, 6'b000000},
      {1'b1, 4'd3,  16'h1234, 16'h1234, 16'h0000, 6'b010010},
      {1'b0, 4'd15, 16'h0000, 16'h0000, 16'h0000, 6'b110011},
      {1'b0, 4'd11, 16'h8000, 16'h0000, 16'h0001, 6'b100001},
      {1'b1, 4'd12, 16'h0000, 16'h0000, 16'hFFFF, 6'b001011},
      {1'b0, 4'd12, 16'h0002, 16'h0000, 16'h8001, 6'b001000},
      {1'b1, 4'd15, 16'h0001, 16'h0002, 16'h0001, 6'b000000},
      {1'b0, 4'd4,  16'h0005, 16'h0003, 16'h0001, 6'b100001}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      go(v[i][58], v[i][57:54], v[i][53:38], v[i][37:22]);
      exp_st = {1'b1, v[i][21:0]};
      n_cmp++;
      if (st !== exp_st) begin n_bad++; $display("FAIL b2b_vec%0d: got %h want %h", i, st, exp_st); end
    end
    in_valid = 1'b0;
    step();
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    go(1'b0, 4'd1, 16'h0001, 16'h0002);
    exp_st = {1'b1, 16'h0003, 6'b000000};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL bp_first: got %h want %h", st, exp_st); end
    in_a = 16'h0004; in_b = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); end
      n_cmp++;
      if (st !== exp_st) begin n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i, st, exp_st); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    exp_st = {1'b1, 16'h0009, 6'b000000};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL bp_swap: got %h want %h", st, exp_st); end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask
  task automatic test_async_reset();
    out_ready = 1'b0;
    go(1'b0, 4'd14, 16'h8000, 16'h0000);
    exp_st = {1'b1, 16'h8000, 6'b001000};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL ar_pending: got %h want %h", st, exp_st); end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_st = {1'b0, 16'h0000, 6'b000001};
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL ar_clear: got %h want %h", st, exp_st); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    #3 rst = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (st !== exp_st) begin n_bad++; $display("FAIL ar_after: got %h want %h", st, exp_st); end
  endtask
  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
